// File: rtl/ped_request_conditioner.sv
// Pedestrian push-button conditioner: synchronise, debounce, and turn each clean press
// into a held request level that the slow controller FSM clears by starting the walk phase.
module ped_request_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int COOLDOWN_CYCLES = 8,
  parameter int CNT_W           = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_raw,
  input  logic       ped_walk,
  output logic       pedestrian_btn,
  output logic       btn_clean,
  output logic       press_pulse,
  output logic       wait_led,
  output logic [7:0] accepted_count,
  output logic [1:0] fsm_state
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQUESTED = 2'd1,
    SERVING   = 2'd2,
    COOLDOWN  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CD_LAST = CNT_W'((COOLDOWN_CYCLES > 0) ? COOLDOWN_CYCLES - 1 : 0);

  logic             btn_s1, s_btn;
  logic             walk_s1, s_walk;
  logic [CNT_W-1:0] db_cnt;
  logic [CNT_W-1:0] cd_cnt;
  state_t           state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_s1  <= 1'b0;
      s_btn   <= 1'b0;
      walk_s1 <= 1'b0;
      s_walk  <= 1'b0;
    end else begin
      btn_s1  <= btn_raw;
      s_btn   <= btn_s1;
      walk_s1 <= ped_walk;
      s_walk  <= walk_s1;
    end
  end

  // Debounce: the synchronised level must disagree with btn_clean for
  // DEBOUNCE_CYCLES consecutive samples; the pulse is raised on the same edge
  // that btn_clean flips high, so it lines up with the first cycle it reads 1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      db_cnt      <= '0;
      btn_clean   <= 1'b0;
      press_pulse <= 1'b0;
    end else begin
      press_pulse <= 1'b0;
      if (s_btn == btn_clean) begin
        db_cnt <= '0;
      end else if (db_cnt >= DB_LAST) begin
        db_cnt      <= '0;
        btn_clean   <= s_btn;
        press_pulse <= s_btn;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  // Request FSM; pedestrian_btn is registered alongside the state so it is
  // high exactly while the state is REQUESTED.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      cd_cnt         <= '0;
      pedestrian_btn <= 1'b0;
      accepted_count <= 8'd0;
    end else begin
      pedestrian_btn <= 1'b0;
      case (state)
        IDLE: begin
          if (s_walk) begin
            state <= SERVING;
          end else if (press_pulse) begin
            state          <= REQUESTED;
            pedestrian_btn <= 1'b1;
            accepted_count <= accepted_count + 8'd1;
          end
        end
        REQUESTED: begin
          if (s_walk) state <= SERVING;
          else        pedestrian_btn <= 1'b1;
        end
        SERVING: begin
          if (!s_walk) begin
            if (COOLDOWN_CYCLES == 0) begin
              state <= IDLE;
            end else begin
              state  <= COOLDOWN;
              cd_cnt <= '0;
            end
          end
        end
        COOLDOWN: begin
          if (s_walk)                 state <= SERVING;
          else if (cd_cnt >= CD_LAST) state <= IDLE;
          else                        cd_cnt <= cd_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign wait_led  = pedestrian_btn;
  assign fsm_state = state;

endmodule

// File: tb/tb_ped_request_conditioner.sv
// Bench for ped_request_conditioner: hand-written timing sequences plus a
// table of button pulse widths checked through an expected-value queue.
module tb_ped_request_conditioner;

  localparam logic [1:0] S_IDLE = 2'd0, S_REQ = 2'd1, S_SERV = 2'd2, S_COOL = 2'd3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_raw = 1'b0;
  logic       ped_walk = 1'b0;
  logic       pedestrian_btn, btn_clean, press_pulse, wait_led;
  logic [7:0] accepted_count;
  logic [1:0] fsm_state;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;
  logic [10:0] exp_q[$];

  typedef struct {
    int   len;
    logic serve;
    int   exp_pulses;
    logic exp_req;
    int   exp_count;
  } vec_t;
  vec_t vecs[7];

  ped_request_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .COOLDOWN_CYCLES(8),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_raw(btn_raw),
    .ped_walk(ped_walk),
    .pedestrian_btn(pedestrian_btn),
    .btn_clean(btn_clean),
    .press_pulse(press_pulse),
    .wait_led(wait_led),
    .accepted_count(accepted_count),
    .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (press_pulse === 1'b1) pulse_cnt++;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_ped_btn"}, 32'(pedestrian_btn), 0);
    chk({tag, "_wait_led"}, 32'(wait_led), 0);
    chk({tag, "_btn_clean"}, 32'(btn_clean), 0);
    chk({tag, "_press_pulse"}, 32'(press_pulse), 0);
    chk({tag, "_count"}, 32'(accepted_count), 0);
    chk({tag, "_state"}, 32'(fsm_state), 32'(S_IDLE));
  endtask

  // One accepted press followed by a full walk phase and cooldown, back to IDLE.
  task automatic press_and_serve();
    btn_raw = 1'b1;
    tick(8);
    btn_raw  = 1'b0;
    ped_walk = 1'b1;
    tick(4);
    ped_walk = 1'b0;
    tick(12);
  endtask

  initial begin
    logic [10:0] got_exp;
    int lat;
    bit found;

    vecs[0] = '{1,  1'b0, 0, 1'b0, 0};
    vecs[1] = '{3,  1'b0, 0, 1'b0, 0};
    vecs[2] = '{4,  1'b0, 1, 1'b1, 1};
    vecs[3] = '{6,  1'b1, 1, 1'b1, 1};
    vecs[4] = '{2,  1'b0, 0, 1'b0, 1};
    vecs[5] = '{10, 1'b1, 1, 1'b1, 2};
    vecs[6] = '{5,  1'b0, 1, 1'b1, 3};

    // Reset held with the button down, then released: clean press after 2+4 edges.
    btn_raw = 1'b1;
    rst_n   = 1'b0;
    tick(3);
    chk_cleared("reset");
    rst_n = 1'b1;
    tick(5);
    chk("rel_btn_clean_early", 32'(btn_clean), 0);
    tick(1);
    chk("rel_btn_clean", 32'(btn_clean), 1);
    chk("rel_press_pulse", 32'(press_pulse), 1);
    chk("rel_ped_not_yet", 32'(pedestrian_btn), 0);
    tick(1);
    chk("rel_pulse_one_cycle", 32'(press_pulse), 0);
    chk("rel_ped_btn", 32'(pedestrian_btn), 1);
    chk("rel_wait_led", 32'(wait_led), 1);
    chk("rel_count", 32'(accepted_count), 1);
    chk("rel_state", 32'(fsm_state), 32'(S_REQ));
    btn_raw = 1'b0;
    tick(10);
    chk("req_held", 32'(pedestrian_btn), 1);

    // Acknowledge: request drops on the third edge after ped_walk rises.
    ped_walk = 1'b1;
    tick(2);
    chk("ack_not_early", 32'(pedestrian_btn), 1);
    tick(1);
    chk("ack_drop", 32'(pedestrian_btn), 0);
    chk("ack_state", 32'(fsm_state), 32'(S_SERV));

    // Press during SERVING is ignored.
    btn_raw = 1'b1;
    tick(8);
    btn_raw = 1'b0;
    chk("serv_press_count", 32'(accepted_count), 1);
    chk("serv_press_ped", 32'(pedestrian_btn), 0);
    tick(8);

    // Walk ends; a press landing inside cooldown is ignored; IDLE after 8 cooldown cycles.
    pulse_cnt = 0;
    ped_walk  = 1'b0;
    btn_raw   = 1'b1;
    tick(10);
    chk("cool_state", 32'(fsm_state), 32'(S_COOL));
    chk("cool_press_seen", 32'(pulse_cnt), 1);
    chk("cool_press_count", 32'(accepted_count), 1);
    tick(1);
    chk("cool_to_idle", 32'(fsm_state), 32'(S_IDLE));
    btn_raw = 1'b0;
    tick(10);
    chk("cool_no_queue_ped", 32'(pedestrian_btn), 0);
    chk("cool_no_queue_count", 32'(accepted_count), 1);

    // Fresh press after lockout is accepted.
    btn_raw = 1'b1;
    tick(8);
    chk("post_cool_count", 32'(accepted_count), 2);
    chk("post_cool_ped", 32'(pedestrian_btn), 1);
    btn_raw = 1'b0;
    tick(10);

    // Reset for one cycle in the middle of cooldown.
    ped_walk = 1'b1;
    tick(6);
    ped_walk = 1'b0;
    tick(6);
    chk("mid_cool_state", 32'(fsm_state), 32'(S_COOL));
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    chk_cleared("mid_reset");
    tick(3);

    // Bounce: 2-cycle toggles never survive the debounce window.
    pulse_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      btn_raw = (i % 2 == 0);
      tick(2);
    end
    chk("bounce_no_pulse", 32'(pulse_cnt), 0);
    chk("bounce_btn_clean", 32'(btn_clean), 0);
    btn_raw = 1'b1;
    lat   = 0;
    found = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      if (press_pulse === 1'b1 && !found) begin
        found = 1'b1;
        lat   = k;
      end
    end
    chk("bounce_latency", 32'(lat), 6);
    chk("bounce_one_pulse", 32'(pulse_cnt), 1);
    chk("bounce_count", 32'(accepted_count), 1);
    btn_raw  = 1'b0;
    ped_walk = 1'b1;
    tick(5);
    ped_walk = 1'b0;
    tick(12);
    chk("bounce_served_idle", 32'(fsm_state), 32'(S_IDLE));

    // Unsolicited walk arriving on the same cycle as a press: walk wins, no count.
    pulse_cnt = 0;
    btn_raw   = 1'b1;
    tick(4);
    ped_walk = 1'b1;
    tick(3);
    chk("unsol_pulse_seen", 32'(pulse_cnt), 1);
    chk("unsol_state", 32'(fsm_state), 32'(S_SERV));
    chk("unsol_ped", 32'(pedestrian_btn), 0);
    chk("unsol_count", 32'(accepted_count), 1);
    btn_raw = 1'b0;
    tick(4);
    chk("unsol_ped_later", 32'(pedestrian_btn), 0);
    ped_walk = 1'b0;
    tick(14);
    chk("unsol_idle", 32'(fsm_state), 32'(S_IDLE));
    chk("unsol_count_final", 32'(accepted_count), 1);

    // Table of button pulse widths, starting from a fresh reset.
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(2);
    for (int i = 0; i < 7; i++) begin
      pulse_cnt = 0;
      exp_q.push_back({2'(vecs[i].exp_pulses), vecs[i].exp_req, 8'(vecs[i].exp_count)});
      btn_raw = 1'b1;
      tick(vecs[i].len);
      btn_raw = 1'b0;
      tick(12);
      got_exp = exp_q.pop_front();
      chk($sformatf("vec%0d_pulses", i), 32'(pulse_cnt), 32'(got_exp[10:9]));
      chk($sformatf("vec%0d_ped", i), 32'(pedestrian_btn), 32'(got_exp[8]));
      chk($sformatf("vec%0d_wait", i), 32'(wait_led), 32'(got_exp[8]));
      chk($sformatf("vec%0d_count", i), 32'(accepted_count), 32'(got_exp[7:0]));
      if (vecs[i].serve) begin
        ped_walk = 1'b1;
        tick(5);
        ped_walk = 1'b0;
        tick(12);
        chk($sformatf("vec%0d_served_idle", i), 32'(fsm_state), 32'(S_IDLE));
        chk($sformatf("vec%0d_served_ped", i), 32'(pedestrian_btn), 0);
      end
    end

    // 256 accepted presses wrap the counter back to zero.
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(2);
    for (int i = 0; i < 255; i++) press_and_serve();
    chk("wrap_255", 32'(accepted_count), 255);
    chk("wrap_idle", 32'(fsm_state), 32'(S_IDLE));
    press_and_serve();
    chk("wrap_0", 32'(accepted_count), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
